// File: rtl/alu_sequencer.sv
// Command sequencer around an external combinational ALU: holds R0-R3 and a flags
// register, issues one operation at a time and returns a held response.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [3:0] cmd_opcode,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs1,
  input  logic [1:0] cmd_rs2,
  input  logic [7:0] cmd_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [7:0] alu_out,
  input  logic [7:0] alu_flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [7:0] rsp_flags,
  output logic       rsp_err
);

  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_CMP = 4'b1110;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t     state_reg, state_next;
  logic [7:0] regs_reg [4];
  logic [7:0] flags_reg;
  logic [7:0] op_a_reg, op_b_reg, imm_reg;
  logic [3:0] opcode_reg;
  logic [1:0] rd_reg;
  logic       load_reg;
  logic [7:0] rsp_data_reg, rsp_flags_reg;
  logic       rsp_err_reg;

  logic       accept, capture, wr_en, res_err;
  logic [7:0] wr_data, res_data, res_flags;

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_opcode = 4'h0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = ISSUE;
      end
      ISSUE: begin
        alu_a      = op_a_reg;
        alu_b      = op_b_reg;
        alu_opcode = opcode_reg;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept  = (state_reg == IDLE) && cmd_valid;
  assign capture = (state_reg == ISSUE);

  // Load and divide-by-zero leave the flags register alone, so they feed back flags_reg.
  always_comb begin
    wr_en     = capture;
    wr_data   = alu_out;
    res_data  = alu_out;
    res_flags = alu_flags;
    res_err   = 1'b0;
    if (load_reg) begin
      wr_data   = imm_reg;
      res_data  = imm_reg;
      res_flags = flags_reg;
    end else if (opcode_reg == OP_CMP) begin
      wr_en    = 1'b0;
      res_data = 8'h00;
    end else if (opcode_reg == OP_DIV && op_b_reg == 8'h00) begin
      wr_data   = 8'hFF;
      res_data  = 8'hFF;
      res_flags = flags_reg;
      res_err   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      for (int i = 0; i < 4; i++) regs_reg[i] <= 8'h00;
      flags_reg     <= 8'h00;
      op_a_reg      <= 8'h00;
      op_b_reg      <= 8'h00;
      imm_reg       <= 8'h00;
      opcode_reg    <= 4'h0;
      rd_reg        <= 2'd0;
      load_reg      <= 1'b0;
      rsp_data_reg  <= 8'h00;
      rsp_flags_reg <= 8'h00;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_a_reg   <= regs_reg[cmd_rs1];
        op_b_reg   <= regs_reg[cmd_rs2];
        imm_reg    <= cmd_imm;
        opcode_reg <= cmd_opcode;
        rd_reg     <= cmd_rd;
        load_reg   <= cmd_load;
      end
      if (capture) begin
        if (wr_en) regs_reg[rd_reg] <= wr_data;
        flags_reg     <= res_flags;
        rsp_data_reg  <= res_data;
        rsp_flags_reg <= res_flags;
        rsp_err_reg   <= res_err;
      end
    end
  end

  assign rsp_data  = rsp_data_reg;
  assign rsp_flags = rsp_flags_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a reference combinational ALU attached.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, cmd_ready, cmd_load;
  logic [3:0] cmd_opcode, alu_opcode;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [7:0] cmd_imm, alu_a, alu_b, alu_out, alu_flags;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_data, rsp_flags;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_opcode(cmd_opcode), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] flags;
    logic       err;
  } rsp_t;

  rsp_t       exp_q [$];
  logic [7:0] m_regs [4];
  logic [7:0] m_flags;
  logic [8:0] want_a;
  int         checks = 0;
  int         errors = 0;

  // Reference ALU: flags = {5'b0, negative, carry/borrow, zero}.
  function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
    logic [8:0] w;
    logic [7:0] r;
    logic       c;
    w = 9'h000;
    r = 8'h00;
    c = 1'b0;
    case (op)
      4'h0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; end
      4'h1, 4'hE: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; end
      4'h2: r = a & b;
      4'h3: r = (b == 8'h00) ? 8'hFF : a / b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: begin r = {a[6:0], a[7]}; c = a[7]; end
      default: r = 8'h00;
    endcase
    return {5'b00000, r[7], c, (r == 8'h00), r};
  endfunction

  always_comb begin
    alu_out   = ref_alu(alu_a, alu_b, alu_opcode) >> 0;
    alu_flags = ref_alu(alu_a, alu_b, alu_opcode) >> 8;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    rsp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_rsp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        $display("rsp data=%02h flags=%02h err=%0b (exp %02h %02h %0b)",
                 rsp_data, rsp_flags, rsp_err, e.data, e.flags, e.err);
        check_eq("rsp_data", rsp_data, e.data);
        check_eq("rsp_flags", rsp_flags, e.flags);
        check_eq("rsp_err", rsp_err, e.err);
      end
    end
  end

  task automatic send(input logic ld, input logic [3:0] op, input logic [1:0] rd,
                      input logic [1:0] rs1, input logic [1:0] rs2,
                      input logic [7:0] imm, input int stall);
    logic [7:0]  a, b, res_d, res_f, issue_flags;
    logic [15:0] r;
    logic        err;
    rsp_t        e;
    int          n;
    a   = m_regs[rs1];
    b   = m_regs[rs2];
    r   = ref_alu(a, b, op);
    err = 1'b0;
    if (ld) begin
      res_d = imm; res_f = m_flags; m_regs[rd] = imm;
    end else if (op == 4'hE) begin
      res_d = 8'h00; res_f = r[15:8]; m_flags = res_f;
    end else if (op == 4'h3 && b == 8'h00) begin
      res_d = 8'hFF; res_f = m_flags; err = 1'b1; m_regs[rd] = 8'hFF;
    end else begin
      res_d = r[7:0]; res_f = r[15:8]; m_flags = res_f; m_regs[rd] = res_d;
    end
    e.data = res_d; e.flags = res_f; e.err = err;
    exp_q.push_back(e);

    rsp_ready  = (stall == 0);
    cmd_valid  = 1'b1;
    cmd_load   = ld;
    cmd_opcode = op;
    cmd_rd     = rd;
    cmd_rs1    = rs1;
    cmd_rs2    = rs2;
    cmd_imm    = imm;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check_eq("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_eq("issue_ready", cmd_ready, 0);
    check_eq("issue_valid", rsp_valid, 0);
    if (!ld) begin
      check_eq("alu_a", alu_a, a);
      check_eq("alu_b", alu_b, b);
    end
    if (want_a[8]) check_eq("reg_value", alu_a, want_a[7:0]);
    check_eq("alu_opcode", alu_opcode, op);
    issue_flags = alu_flags;
    @(posedge clk); #1;
    check_eq("resp_valid", rsp_valid, 1);
    if (!ld && op == 4'hE) check_eq("cmp_flags", rsp_flags, issue_flags);
    if (stall > 0) begin
      cmd_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        check_eq("stall_valid", rsp_valid, 1);
        check_eq("stall_data", rsp_data, res_d);
        check_eq("stall_ready", cmd_ready, 0);
        @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      check_eq("stall_valid_last", rsp_valid, 1);
    end
    @(posedge clk); #1;
    check_eq("idle_ready", cmd_ready, 1);
    check_eq("idle_valid", rsp_valid, 0);
    check_eq("rsp_hold", rsp_data, res_d);
  endtask

  // Read a register through a compare, which writes nothing; alu_a carries the value.
  task automatic read_reg(input logic [1:0] idx, input logic [7:0] expv);
    want_a = {1'b1, expv};
    send(1'b0, 4'hE, 2'd0, idx, idx, 8'h00, 0);
    want_a = 9'h000;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_flags = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    want_a = 9'h000;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_opcode = 4'h0;
    cmd_rd = 2'd0; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_imm = 8'h00; rsp_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_valid", rsp_valid, 0);
    check_eq("rst_data", rsp_data, 0);
    check_eq("rst_flags", rsp_flags, 0);
    check_eq("rst_err", rsp_err, 0);
    check_eq("rst_alu_a", alu_a, 0);

    // add
    send(1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 8'h05, 0);
    send(1'b1, 4'h0, 2'd2, 2'd0, 2'd0, 8'h03, 0);
    send(1'b0, 4'h0, 2'd3, 2'd1, 2'd2, 8'h00, 0);
    read_reg(2'd3, 8'h08);
    // divide by zero, then a normal divide and sub/xor
    send(1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 8'h10, 0);
    send(1'b1, 4'h0, 2'd2, 2'd0, 2'd0, 8'h00, 0);
    send(1'b0, 4'h3, 2'd0, 2'd1, 2'd2, 8'h00, 0);
    read_reg(2'd0, 8'hFF);
    send(1'b1, 4'h0, 2'd2, 2'd0, 2'd0, 8'h03, 0);
    send(1'b0, 4'h3, 2'd2, 2'd1, 2'd2, 8'h00, 0);
    read_reg(2'd2, 8'h05);
    send(1'b0, 4'h1, 2'd3, 2'd2, 2'd1, 8'h00, 0);
    send(1'b0, 4'h5, 2'd0, 2'd0, 2'd3, 8'h00, 0);
    // compare leaves rd untouched
    send(1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 8'h22, 0);
    send(1'b1, 4'h0, 2'd2, 2'd0, 2'd0, 8'h22, 0);
    send(1'b1, 4'h0, 2'd3, 2'd0, 2'd0, 8'h7E, 0);
    send(1'b0, 4'hE, 2'd3, 2'd1, 2'd2, 8'h00, 0);
    read_reg(2'd3, 8'h7E);
    // backpressure
    send(1'b0, 4'h0, 2'd0, 2'd1, 2'd2, 8'h00, 3);
    read_reg(2'd0, 8'h44);

    // reset during ISSUE of an add to R2
    send(1'b1, 4'h0, 2'd2, 2'd0, 2'd0, 8'h44, 0);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_opcode = 4'h0;
    cmd_rd = 2'd2; cmd_rs1 = 2'd1; cmd_rs2 = 2'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_eq("mid_issue_a", alu_a, 8'h22);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check_eq("mid_rst_ready", cmd_ready, 1);
    check_eq("mid_rst_data", rsp_data, 0);
    for (int i = 0; i < 3; i++) begin
      check_eq("mid_rst_no_rsp", rsp_valid, 0);
      @(posedge clk); #1;
    end
    read_reg(2'd2, 8'h00);

    // rotate-left with rd = rs1
    send(1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 8'h81, 0);
    send(1'b0, 4'h6, 2'd1, 2'd1, 2'd1, 8'h00, 0);
    read_reg(2'd1, 8'h03);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL use the following ports (name  direction  width  meaning):
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_load  input  1  1 = load immediate into rd; 0 = ALU operation.
REQ-007 cmd_opcode  input  4  ALU opcode, ignored when cmd_load=1.
REQ-008 cmd_rd, cmd_rs1, cmd_rs2  input  2 each  destination and source register indices.
REQ-009 cmd_imm  input  8  immediate for load.
REQ-010 alu_a, alu_b  output  8 each  operands driven to the combinational ALU.
REQ-011 alu_opcode  output  4  opcode driven to the ALU.
REQ-012 alu_out  input  8  ALU result, valid combinationally within the same cycle.
REQ-013 alu_flags  input  8  ALU flags, valid combinationally within the same cycle.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  consumer accepts the response.
REQ-016 rsp_data  output  8  result written, or 0x00 for compare.
REQ-017 rsp_flags  output  8  contents of the flags register after the command.
REQ-018 rsp_err  output  1  divide-by-zero detected.
REQ-019 The block SHALL have no parameters; data width is fixed at 8 and there are 4 registers R0-R3.

Function
REQ-020 State machine states SHALL be IDLE, ISSUE and RESP.
REQ-021 In IDLE, cmd_ready SHALL be 1; in ISSUE and RESP, cmd_ready SHALL be 0.
REQ-022 A command SHALL be accepted only on a clock edge with cmd_valid=1 and cmd_ready=1.
REQ-023 On acceptance, the block SHALL latch R[rs1] and R[rs2] into operand registers op_a and op_b, latch the remaining command fields, and move IDLE->ISSUE.
REQ-024 In ISSUE, alu_a SHALL equal op_a, alu_b SHALL equal op_b and alu_opcode SHALL equal the latched opcode.
REQ-025 In all other states, alu_a, alu_b and alu_opcode SHALL be 0.
REQ-026 At the end of the ISSUE cycle the block SHALL capture the result and move ISSUE->RESP.
REQ-027 Load capture: R[rd] <= imm; rsp_data = imm; flags register unchanged.
REQ-028 Compare capture (opcode 0b1110): flags register <= alu_flags; no register write; rsp_data = 0x00.
REQ-029 Divide capture (opcode 0b0011) with op_b = 0x00: R[rd] <= 0xFF; rsp_data = 0xFF; rsp_err = 1; flags register unchanged.
REQ-030 All other opcodes, including divide with op_b != 0x00: R[rd] <= alu_out; flags register <= alu_flags; rsp_data = alu_out.
REQ-031 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_flags and rsp_err SHALL be held stable until a handshake occurs.
REQ-032 A response handshake SHALL occur on an edge with rsp_valid=1 and rsp_ready=1, and SHALL move RESP->IDLE.
REQ-033 rsp_ready=0 SHALL stall the block in RESP indefinitely.
REQ-034 rsp_valid SHALL be 0 outside RESP; rsp_data, rsp_flags and rsp_err SHALL keep their last values outside RESP.
REQ-035 Latency: a command accepted at edge n SHALL give rsp_valid=1 in the cycle following edge n+1; with rsp_ready=1 throughout, the next command SHALL be accepted no earlier than edge n+3.
REQ-036 Source operands SHALL be read at acceptance, so rs1=rs2=rd SHALL use pre-write values.
REQ-037 Back-to-back commands SHALL observe all prior register writes; no hazard handling is needed.
REQ-038 Register indices SHALL address R0-R3 with no wrap or aliasing; R0 is an ordinary writable register.
REQ-039 Register writes SHALL be exactly one per command, except compare, which performs none.
REQ-040 cmd_* inputs SHALL be ignored outside IDLE.

Reset
REQ-041 On a clock edge with rst_n=0, the block SHALL set state to IDLE, R0-R3 to 0x00, the flags register to 0x00, op_a and op_b to 0x00, rsp_data to 0x00, rsp_flags to 0x00, rsp_err to 0, and rsp_valid to 0.
REQ-042 After reset, cmd_ready SHALL be 1 in the first cycle with rst_n=1.
REQ-043 Reset asserted in ISSUE or RESP SHALL abandon the command: no register write occurs and no response is produced.
REQ-044 Reset SHALL take priority over any simultaneous handshake.

Verification
REQ-045 Scenario, add: load R1=0x05, load R2=0x03, then add (0b0000) rd=R3, rs1=R1, rs2=R2 with a reference ALU model -> alu_a=0x05, alu_b=0x03 in ISSUE; rsp_data=0x08 two edges after acceptance; R3=0x08.
REQ-046 Scenario, divide by zero: R1=0x10, R2=0x00, divide (0b0011) rd=R0 -> rsp_err=1, rsp_data=0xFF, R0=0xFF, rsp_flags equal to the prior value.
REQ-047 Scenario, compare: R1=0x22, R2=0x22, compare (0b1110) rd=R3 with R3 preset to 0x7E -> R3 stays 0x7E, rsp_data=0x00, rsp_flags equals alu_flags sampled in ISSUE.
REQ-048 Scenario, backpressure: rsp_ready=0 for 3 cycles during RESP -> rsp_valid held at 1, rsp_data stable, cmd_ready=0 with cmd_valid=1; handshake on the 4th cycle -> cmd_ready=1 the next cycle.
REQ-049 Scenario, reset mid-operation: rst_n=0 during ISSUE of an add to R2 preset to 0x44 -> R2 reads 0x00 after reset (reset value), no rsp_valid pulse, cmd_ready=1 after release.
REQ-050 Scenario, aliasing: R1=0x81, rotate-left (0b0110) rd=R1, rs1=R1 -> alu_a=0x81 in ISSUE, R1 becomes alu_out (0x03 with the reference ALU model).
